// File: rtl/swmon_pkg.sv
// Shared types and electrical figures for the switch activity monitor.
// The capacitance/supply defaults match those used by the behavioural gate models.
package swmon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEASURE = 3'd2,
    CALC    = 3'd3,
    REPORT  = 3'd4
  } swmon_state_t;

  localparam int CL_PF_DEF  = 50;
  localparam int VCC_MV_DEF = 3300;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous net followed by a previous-sample
// flop; toggle flags a change between the synchronized value and the last sample.
module sync_edge_det (
  input  logic clk,
  input  logic reset_L,
  input  logic d,
  input  logic load_prev,
  output logic toggle
);

  logic s1;
  logic s2;
  logic p;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      // p only tracks s2 while armed/measuring so a fresh window never sees a stale edge
      if (load_prev) p <= s2;
    end
  end

  assign toggle = (s2 != p);

endmodule

// File: rtl/switch_activity_monitor.sv
// Counts transitions of an observed net over a programmable window and converts
// the count to switched charge (fC); the result is offered on a valid/ready port.
module switch_activity_monitor
  import swmon_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WINDOW_DEF = 1000,
  parameter int CL_PF      = CL_PF_DEF,
  parameter int VCC_MV     = VCC_MV_DEF,
  parameter int Q_W        = 40
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             sig_in,
  input  logic             start,
  input  logic [CNT_W-1:0] window_len,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] toggle_count,
  output logic [Q_W-1:0]   charge_fc,
  output logic             overflow,
  output swmon_state_t     dbg_state
);

  // Result handshake: a result transfers on a clock edge where res_valid and
  // res_ready are both high; res_valid stays high and the data stays stable
  // until then, and it does not depend combinationally on res_ready.

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [Q_W-1:0]   Q_PER_TOGGLE = Q_W'(CL_PF * VCC_MV);

  swmon_state_t     state;
  swmon_state_t     state_next;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_eff;
  logic             toggle;
  logic             load_prev;

  assign win_eff   = (window_len == '0) ? CNT_W'(WINDOW_DEF) : window_len;
  assign load_prev = (state == ARM) || (state == MEASURE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  sync_edge_det u_sync (
    .clk       (clk),
    .reset_L   (reset_L),
    .d         (sig_in),
    .load_prev (load_prev),
    .toggle    (toggle)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ARM;
      ARM:     state_next = MEASURE;
      MEASURE: if (win_cnt == CNT_W'(1)) state_next = CALC;
      CALC:    state_next = REPORT;
      REPORT:  if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      win_cnt      <= '0;
      toggle_count <= '0;
      charge_fc    <= '0;
      overflow     <= 1'b0;
      res_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) win_cnt <= win_eff;
        end
        ARM: begin
          toggle_count <= '0;
          charge_fc    <= '0;
          overflow     <= 1'b0;
        end
        MEASURE: begin
          win_cnt <= win_cnt - CNT_W'(1);
          if (toggle) begin
            if (toggle_count != CNT_MAX) toggle_count <= toggle_count + CNT_W'(1);
            // flag as soon as the counter reaches its ceiling
            if (toggle_count >= CNT_MAX - CNT_W'(1)) overflow <= 1'b1;
          end
        end
        CALC: begin
          charge_fc <= Q_W'(toggle_count) * Q_PER_TOGGLE;
          res_valid <= 1'b1;
        end
        REPORT: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_activity_monitor.sv
// Randomized bench for switch_activity_monitor: transitions are counted from a
// per-cycle history of sig_in and compared with the reported result.
module tb_switch_activity_monitor;
  import swmon_pkg::*;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        sig;
  logic        start;
  logic [15:0] win;
  logic        ready;
  logic        busy;
  logic        res_valid;
  logic [15:0] cnt;
  logic [39:0] chg;
  logic        ovf;
  swmon_state_t st;

  logic [3:0]  win_b;
  logic        busy_b;
  logic        res_valid_b;
  logic [3:0]  cnt_b;
  logic [39:0] chg_b;
  logic        ovf_b;
  swmon_state_t st_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mode = 0;
  bit hist [0:29999];

  assign win_b = win[3:0];

  always #5 clk = ~clk;

  switch_activity_monitor dut (
    .clk(clk), .reset_L(reset_L), .sig_in(sig), .start(start), .window_len(win),
    .busy(busy), .res_valid(res_valid), .res_ready(ready), .toggle_count(cnt),
    .charge_fc(chg), .overflow(ovf), .dbg_state(st)
  );

  switch_activity_monitor #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset_L(reset_L), .sig_in(sig), .start(start), .window_len(win_b),
    .busy(busy_b), .res_valid(res_valid_b), .res_ready(1'b1), .toggle_count(cnt_b),
    .charge_fc(chg_b), .overflow(ovf_b), .dbg_state(st_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // mode: 0 random, 1 square wave period 10, 2 hold, 3 toggle every cycle
  task automatic step();
    case (mode)
      0:       if ($urandom_range(0, 2) == 0) sig = ~sig;
      1:       sig = ((cyc / 5) % 2) != 0;
      3:       sig = ~sig;
      default: ;
    endcase
    hist[cyc] = sig;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // transitions of sig across cycles cs-1 .. cs+L-1 (start high in cycle cs)
  function automatic int model_count(input int cs, input int len);
    int n = 0;
    for (int c = cs; c < cs + len; c++)
      if (hist[c] != hist[c-1]) n++;
    return n;
  endfunction

  task automatic run(input int wl, input int md, input int bp, input bit start_in_report);
    int len;
    int cs;
    int lat;
    int raw;
    longint exp_cnt;
    longint exp_chg;
    len = (wl == 0) ? 1000 : wl;
    mode = md;
    win = 16'(wl);
    ready = 1'b0;
    start = 1'b1;
    cs = cyc;
    step();
    start = 1'b0;
    lat = 0;
    while (!res_valid && lat < len + 20) begin
      step();
      lat++;
    end
    chk("latency", lat, len + 2);
    raw = model_count(cs, len);
    exp_cnt = (raw > 65535) ? 65535 : raw;
    exp_chg = exp_cnt * CL_PF_DEF * VCC_MV_DEF;
    chk("count", cnt, exp_cnt);
    chk("charge", chg, exp_chg);
    chk("overflow", ovf, raw >= 65535);
    chk("busy_report", busy, 1);
    for (int i = 0; i < bp; i++) begin
      if (start_in_report && i == bp / 2) start = 1'b1;
      step();
      start = 1'b0;
      chk("hold_valid", res_valid, 1);
      chk("hold_count", cnt, exp_cnt);
      chk("hold_charge", chg, exp_chg);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("valid_clear", res_valid, 0);
    chk("busy_drop", busy, 0);
    chk("post_count", cnt, exp_cnt);
  endtask

  initial begin
    reset_L = 1'b0;
    sig = 1'b0;
    start = 1'b0;
    win = '0;
    ready = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_count", cnt, 0);
    chk("rst_charge", chg, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_state", st, IDLE);
    reset_L = 1'b1;
    repeat (2) step();

    // reset in the middle of a measurement
    mode = 0;
    win = 16'd20;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("mid_busy", busy, 1);
    reset_L = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", res_valid, 0);
    chk("arst_count", cnt, 0);
    step();
    reset_L = 1'b1;
    step();
    run(20, 0, 0, 0);

    run(100, 1, 0, 0);
    chk("square_count", cnt, 20);
    chk("square_charge", chg, 3300000);

    // default window with a constant-high net raised well before start
    mode = 2;
    sig = 1'b1;
    repeat (5) step();
    run(0, 2, 0, 0);
    chk("default_count", cnt, 0);

    run(37, 0, 30, 1);

    repeat (3) step();
    run(15, 3, 0, 0);
    chk("sat_count", cnt_b, 15);
    chk("sat_ovf", ovf_b, 1);
    chk("sat_charge", chg_b, 2475000);

    // back-to-back: second start in the first IDLE cycle
    run(40, 3, 0, 0);
    run(25, 0, 3, 0);

    for (int k = 0; k < 8; k++) begin
      int md;
      md = $urandom_range(0, 2);
      if (md == 2) md = 3;
      run($urandom_range(1, 60), md, $urandom_range(0, 4), $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_activity_monitor.md
Name: switch_activity_monitor

Overview:
- Sequential counterpart to the team's behavioural gate models: it observes a gate's output net instead of driving one.
- Counts output transitions over a programmable window of clock cycles.
- Converts the count into switched charge using the same load-capacitance and supply figures the gate models use.
- Sits in the testbench/measurement layer beside the combinational gate models.
- Results are returned through a valid/ready handshake.

Parameters:
- CNT_W, 16: width of toggle counter and window length.
- WINDOW_DEF, 1000: window length in cycles, used when window_len is 0.
- CL_PF, 50: load capacitance per toggle, in pF.
- VCC_MV, 3300: supply voltage, in mV.
- Q_W, 40: width of the charge result, in fC (pF·mV).

Ports:
- clk  in  1  system clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- sig_in  in  1  monitored net; asynchronous to clk.
- start  in  1  single-cycle pulse that begins a measurement.
- window_len  in  CNT_W  window length in cycles; 0 selects WINDOW_DEF. Sampled on the accepted start.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- toggle_count  out  CNT_W  number of transitions counted in the window.
- charge_fc  out  Q_W  toggle_count*CL_PF*VCC_MV.
- overflow  out  1  toggle counter saturated during the window.

Behaviour:
- Reset (reset_L low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0; synchronizer flops and the previous-sample flop go to 0.
  - Takes effect immediately, including mid-measurement or mid-report; the in-progress result is discarded.
- Input path:
  - sig_in passes through a 2-flop synchronizer (s1, s2), then a previous-sample flop p.
  - A toggle is detected when s2 != p.
  - A change on sig_in is first detectable 2 cycles after the clk edge that captures it into s1.
- FSM states: IDLE, ARM, MEASURE, CALC, REPORT.
  - IDLE: start=1 moves to ARM. start is ignored in every other state.
  - ARM (1 cycle):
    - Latch L = (window_len==0 ? WINDOW_DEF : window_len).
    - Clear the counter and overflow.
    - Load p <= s2, so the first MEASURE cycle cannot count a stale edge.
  - MEASURE: lasts exactly L cycles.
    - Each cycle with s2 != p increments the counter.
    - p <= s2 every cycle.
    - A down-counter expiring to 0 moves the FSM to CALC.
  - CALC (1 cycle): charge_fc <= count*CL_PF*VCC_MV, computed at Q_W width with no truncation for default parameters.
  - REPORT: res_valid=1; toggle_count, charge_fc and overflow are held stable.
    - res_valid && res_ready moves to IDLE and clears res_valid on the next edge.
    - Results remain readable after the handshake until the next ARM.
- Saturation: the counter stops at 2^CNT_W-1, and overflow sets and stays set until the next ARM.
- Latency:
  - Accepted start to res_valid = L+2 cycles (1 ARM + L MEASURE + 1 CALC).
  - With res_ready held high, busy drops at L+3.
- Simultaneous start and res_ready in REPORT: start is ignored.
- busy is combinational from the state register; all other outputs are registered.

Decomposition:
- Shared package (swmon_pkg) holds:
  - state enumeration IDLE/ARM/MEASURE/CALC/REPORT;
  - default constants CL_PF_DEF=50 and VCC_MV_DEF=3300, shared with the gate models' electrical figures.
- One sub-module, sync_edge_det: 2-flop synchronizer plus previous-sample flop.
  - Inputs: clk, reset_L, d, load_prev.
  - Output: toggle.
- The FSM, counters and multiply stay in the top level.

Test Plan:
- Reset mid-MEASURE: start with window_len=20, hold reset_L low for 1 cycle at cycle 10 -> busy=0, res_valid=0, toggle_count=0 immediately; a new start then completes normally.
- Square wave: window_len=100, sig_in toggling every 5 cycles, phase-locked -> toggle_count=20, charge_fc=3,300,000, overflow=0, res_valid rises 102 cycles after start.
- Default window: window_len=0, sig_in constant 1 but set high before start -> L=1000, toggle_count=0, charge_fc=0; no spurious count from the ARM-time value.
- Saturation: CNT_W=4, window_len=15, sig_in toggling every cycle -> count pinned at 15, overflow=1, charge_fc=2,475,000.
- Handshake backpressure: res_ready held low 30 cycles in REPORT -> res_valid and data stable; a start pulse during REPORT is ignored; res_ready=1 returns to IDLE the next cycle.
- Back-to-back runs: second start the cycle after IDLE is entered -> overflow and count cleared at ARM; the second result is independent of the first.
